// File: rtl/jam_pkg.sv
// jam_pkg: shared types and constant helpers for the assignment search.
// Holds the FSM state enum plus clog2/factorial constant functions.
package jam_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CMP,
    FIND_PT,
    FIND_MIN,
    SWAP_REV,
    DONE
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int fact(input int n);
    int f;
    f = 1;
    for (int k = 2; k <= n; k++) f *= k;
    return f;
  endfunction

endpackage

// File: rtl/jam_perm_search_if.sv
// jam_perm_search_if: search control, cost-memory bus and result bundle.
// slave = solver side (START/Cost in), master = requester/memory side.
interface jam_perm_search_if #(
  parameter int N       = 8,
  parameter int COST_W  = 7,
  parameter int MATCH_W = 16
) ();
  import jam_pkg::*;

  localparam int IDX_W = (clog2(N) < 1) ? 1 : clog2(N);
  localparam int SUM_W = COST_W + clog2(N);

  logic               START;
  logic [IDX_W-1:0]   W;
  logic [IDX_W-1:0]   J;
  logic [COST_W-1:0]  Cost;
  logic               BUSY;
  logic               Valid;
  logic [SUM_W-1:0]   MinCost;
  logic [MATCH_W-1:0] MatchCount;
  logic [N*IDX_W-1:0] BestPerm;

  modport master (
    output START, Cost,
    input  W, J, BUSY, Valid, MinCost, MatchCount, BestPerm
  );

  modport slave (
    input  START, Cost,
    output W, J, BUSY, Valid, MinCost, MatchCount, BestPerm
  );

endinterface

// File: rtl/jam_next_perm.sv
// jam_next_perm: permutation register with lexicographic successor step.
// Ports: CLK, RST_N, init, st (scan phase), perm out, last/hit/scan_end.
module jam_next_perm
  import jam_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               init,
  input  state_t             st,
  output logic [N*IDX_W-1:0] perm,
  output logic               last,
  output logic               hit,
  output logic               scan_end
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] PIV0     = IDX_W'(N - 2);

  logic [IDX_W-1:0] pm_q [N];
  logic [IDX_W-1:0] pm_d [N];
  logic [IDX_W-1:0] sw   [N];
  logic [IDX_W-1:0] p_q, q_q, b_q, p1;

  assign p1  = p_q + 1'b1;
  assign hit = (st == FIND_PT) && (pm_q[p_q] < pm_q[p1]);
  assign scan_end = (st == FIND_PT) ? (p_q == '0)
                                    : (q_q == LAST_IDX);

  always_comb begin
    perm = '0;
    for (int k = 0; k < N; k++)
      perm[k*IDX_W +: IDX_W] = pm_q[k];
  end

  // Suffix right of the pivot is descending, so after the swap
  // reversing it yields the smallest successor.
  always_comb begin
    sw = pm_q;
    sw[p_q] = pm_q[b_q];
    sw[b_q] = pm_q[p_q];
    pm_d = pm_q;
    if (init) begin
      for (int k = 0; k < N; k++) pm_d[k] = IDX_W'(k);
    end else if (st == SWAP_REV) begin
      for (int k = 0; k < N; k++) begin
        if (k > int'(p_q)) pm_d[k] = sw[N + int'(p_q) - k];
        else               pm_d[k] = sw[k];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < N; k++) pm_q[k] <= IDX_W'(k);
      p_q  <= '0;
      q_q  <= '0;
      b_q  <= '0;
      last <= 1'b0;
    end else begin
      pm_q <= pm_d;
      if (init) last <= 1'b0;
      unique case (st)
        CMP: p_q <= PIV0;
        FIND_PT: begin
          if (hit) begin
            q_q <= p1;
            b_q <= p1;
          end else if (p_q == '0) begin
            last <= 1'b1;
          end else begin
            p_q <= p_q - 1'b1;
          end
        end
        FIND_MIN: begin
          if (pm_q[q_q] > pm_q[p_q] && pm_q[q_q] < pm_q[b_q])
            b_q <= q_q;
          if (q_q != LAST_IDX) q_q <= q_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/jam_perm_search.sv
// jam_perm_search: exhaustive N x N assignment search over all N! perms.
// Ports: CLK, RST_N, bus (START/Cost in; W/J, BUSY, Valid, results out).
module jam_perm_search
  import jam_pkg::*;
#(
  parameter int N       = 8,
  parameter int COST_W  = 7,
  parameter int MATCH_W = 16
) (
  input logic              CLK,
  input logic              RST_N,
  jam_perm_search_if.slave bus
);

  localparam int IDX_W = (clog2(N) < 1) ? 1 : clog2(N);
  localparam int SUM_W = COST_W + clog2(N);
  localparam int PW    = N * IDX_W;
  localparam logic [IDX_W:0]   CNT_END  = (IDX_W + 1)'(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  function automatic logic [PW-1:0] ident();
    logic [PW-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*IDX_W +: IDX_W] = IDX_W'(k);
    return v;
  endfunction

  localparam logic [PW-1:0] IDENT = ident();

  state_t             st_q, st_d;
  logic [IDX_W:0]     cnt_q;
  logic [SUM_W-1:0]   sum_q, min_q;
  logic [MATCH_W-1:0] match_q;
  logic [PW-1:0]      best_q, perm;
  logic               busy_q, valid_q;
  logic               start_ok, last, hit, scan_end;
  logic [IDX_W-1:0]   fidx;

  assign start_ok = (st_q == IDLE) && bus.START;

  jam_next_perm #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_np (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .init     (start_ok),
    .st       (st_q),
    .perm     (perm),
    .last     (last),
    .hit      (hit),
    .scan_end (scan_end)
  );

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:     if (bus.START) st_d = FETCH;
      FETCH:    if (cnt_q == CNT_END) st_d = CMP;
      CMP:      st_d = last ? DONE : FIND_PT;
      FIND_PT: begin
        if (hit)           st_d = FIND_MIN;
        else if (scan_end) st_d = DONE;
      end
      FIND_MIN: if (scan_end) st_d = SWAP_REV;
      SWAP_REV: st_d = FETCH;
      DONE:     st_d = IDLE;
      default:  st_d = IDLE;
    endcase
  end

  // Address cycle N repeats the last address; its data lands in cycle N.
  always_comb begin
    fidx  = '0;
    bus.W = '0;
    bus.J = '0;
    if (st_q == FETCH) begin
      fidx  = (cnt_q >= CNT_END) ? LAST_IDX : cnt_q[IDX_W-1:0];
      bus.W = fidx;
      bus.J = perm[fidx*IDX_W +: IDX_W];
    end
  end

  assign bus.BUSY       = busy_q;
  assign bus.Valid      = valid_q;
  assign bus.MinCost    = min_q;
  assign bus.MatchCount = match_q;
  assign bus.BestPerm   = best_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      min_q   <= '1;
      match_q <= '0;
      best_q  <= IDENT;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      st_q <= st_d;
      unique case (st_q)
        IDLE: begin
          if (bus.START) begin
            cnt_q   <= '0;
            sum_q   <= '0;
            min_q   <= '1;
            match_q <= '0;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        FETCH: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q != '0)
            sum_q <= sum_q + SUM_W'(bus.Cost);
        end
        CMP: begin
          if (sum_q < min_q) begin
            min_q   <= sum_q;
            match_q <= MATCH_W'(1);
            best_q  <= perm;
          end else if (sum_q == min_q && match_q != '1) begin
            match_q <= match_q + 1'b1;
          end
        end
        SWAP_REV: begin
          cnt_q <= '0;
          sum_q <= '0;
        end
        DONE: begin
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/jam_perm_search.md
Name: jam_perm_search

Overview:
- Parametrised exhaustive job-assignment solver. Enumerates all N! worker→job permutations in lexicographic order and sums each one's cost from an external cost memory.
- Reports the minimum total cost, how many permutations reach it, and the first (lexicographically smallest) minimising permutation.
- Successor to the fixed 8×8 solver. Adds a START/BUSY handshake, restart without reset, best-assignment output and a saturating match counter.

Parameters:
- N, 8: workers = jobs, 2..8.
- COST_W, 7: width of one cost entry.
- IDX_W, $clog2(N) (min 1): index width for W/J.
- SUM_W, COST_W+$clog2(N): total-cost width; cannot overflow.
- MATCH_W, 16: MatchCount width; saturates at all-ones.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle pulse; begins a search when not BUSY.
- W  out  IDX_W  worker index to cost memory.
- J  out  IDX_W  job index to cost memory.
- Cost  in  COST_W  cost(W,J) from the previous cycle's address; 1-cycle read latency.
- BUSY  out  1  high from the cycle after an accepted START until Valid rises.
- Valid  out  1  results valid; held until next accepted START.
- MinCost  out  SUM_W  minimum total cost.
- MatchCount  out  MATCH_W  number of permutations with cost == MinCost.
- BestPerm  out  N*IDX_W  job of worker k in bits [k*IDX_W +: IDX_W], first minimiser.

Behaviour:
- Reset (async, RST_N low):
  - state=IDLE; BUSY=0; Valid=0; MinCost=all-ones; MatchCount=0; BestPerm=identity; W=0; J=0.
  - Reset mid-search abandons the search; no partial result becomes Valid.
- IDLE:
  - START=1 → perm=identity, MinCost=all-ones, MatchCount=0, Valid=0, BUSY=1 → FETCH.
  - START while BUSY is ignored.
- FETCH: N+1 cycles.
  - Cycle k (0..N-1) drives W=k, J=perm[k].
  - Cycles 1..N accumulate Cost into sum (zero-extended to SUM_W); sum is cleared on FETCH entry.
  - W/J hold at the last address in cycle N.
- CMP: 1 cycle.
  - sum<MinCost → MinCost=sum, MatchCount=1, BestPerm=perm.
  - sum==MinCost → MatchCount+1, saturating at 2^MATCH_W-1. BestPerm unchanged, so ties keep the earlier permutation.
  - If the last-permutation flag is set → DONE; else → FIND_PT.
- FIND_PT: scan p from N-2 down, one position per cycle, until perm[p]<perm[p+1].
  - Found → FIND_MIN.
  - p=0 with no ascent → set last flag, → DONE. This case is reachable only after the descending permutation has been costed.
  - Edge: the pivot scan runs after each CMP. The last permutation (N-1..0) is detected after its own CMP, so all N! permutations are costed exactly once.
- FIND_MIN: scan q=p+1..N-1, one per cycle; pick the smallest perm[q] > perm[p].
- SWAP_REV: 1 cycle. Swap perm[p] and perm[q], then reverse perm[p+1..N-1] in place, registered as a single update. → FETCH.
- DONE: 1 cycle. BUSY=0, Valid=1 → IDLE. Outputs hold until the next START.
- Per-permutation cycle cost ≤ (N+1)+1+(N-1)+(N-1)+1.
- W/J values outside FETCH are don't-care. The bench must not check Cost addresses outside FETCH.

Decomposition:
- Shared package jam_pkg holds:
  - state enum (IDLE, FETCH, CMP, FIND_PT, FIND_MIN, SWAP_REV, DONE);
  - clog2 and factorial constant functions, used by the bench for expected counts.
- Sub-module jam_next_perm holds the permutation register file plus the pivot/min scan and swap-reverse logic. Interface: perm vector out, step/init in, last flag out.
- The top holds the FSM, cost accumulation, comparison and result registers.

Test Plan:
- N=8, Cost=0 for all (W,J) → MinCost=0, MatchCount=40320, BestPerm=identity (0,1,...,7), Valid=1, BUSY=0.
- N=8, cost=0 if J==W else 100 → MinCost=0, MatchCount=1, BestPerm=identity. cost=0 if J==7-W else 100 → BestPerm=(7,6,...,0), MatchCount=1.
- N=3, cost rows {{5,9,1},{4,3,8},{2,7,6}} → MinCost=1+3+2=6 (perm 2,1,0), MatchCount=1, BestPerm=(2,1,0). Cross-check against a software enumerator.
- N=4, MATCH_W=4, cost(W,J)=J → every sum 6, MatchCount saturates at 15, BestPerm=(0,1,2,3).
- N=4 run: pulse START again mid-search → ignored, result identical to a single run. Pulse START after Valid → Valid drops next cycle and the second run reproduces the result.
- Assert RST_N low mid-FETCH → outputs take reset values immediately (asynchronously). Then a new START completes correctly.
